// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: default widths and occupancy encoding.
package pipe_pkg;

  localparam int PIPE_W_ID_EX = 128;
  localparam int PIPE_CNT_W   = 16;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  function automatic occ_t occ_count(input logic main_v, input logic skid_v);
    return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used to accumulate downstream stall cycles.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with optional skid entry (macro PIPE_STAGE_SKID_BUF_EN).
// Bubbles present all-zero payload; flush squashes held entries but not the stall count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W_ID_EX,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : '0;

`ifdef PIPE_STAGE_SKID_BUF_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Registered ready: upstream never sees a combinational path from out_ready.
  assign in_ready = ~skid_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
      end else if (push) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end
    end else if (push && !main_valid) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (pop && skid_valid) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (push && main_valid && !pop) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

  assign occupancy = occ_count(main_valid, skid_valid);
`else
  // Single entry: accept whenever the held payload leaves this cycle or none is held.
  assign in_ready = out_ready | ~main_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (push) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (pop) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end
  end

  assign occupancy = occ_count(main_valid, 1'b0);
`endif

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (main_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule
